fir_tdm_ctrl: RTL and testbench

Time-division multiplexing controller that shares a single multi-channel FIR multiply-accumulate datapath among `NumCh` independent sample streams. Per-channel valid/ready handshakes accept one sample at a time under round-robin arbitration. For each accepted sample the controller sequences the datapath: it shifts the sample into the selected channel's delay line, clears the accumulator, then sweeps the coefficient/tap address. It flags the finished result with its channel tag. It sits between the stream sources and the FIR datapath, in place of a single-channel controller.

---
 rtl/fir_tdm_ctrl.sv | 125 ++++++++++++
 tb/tb_fir_tdm_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_ctrl.sv
// Time-division controller sharing one FIR MAC datapath across NumCh streams.
// Round-robin accepts one sample, then sequences shift/flush, a tap sweep and a tagged result strobe.
module fir_tdm_ctrl #(
  parameter int Taps      = 64,
  parameter int AddrWidth = 6,
  parameter int NumCh     = 4,
  parameter int ChWidth   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NumCh-1:0]     inputValid,
  output logic [NumCh-1:0]     inputReady,
  output logic [ChWidth-1:0]   channel,
  output logic [AddrWidth-1:0] address,
  output logic                 shift,
  output logic                 flush,
  output logic                 accEn,
  output logic                 outputValid,
  output logic [ChWidth-1:0]   outputChannel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [ChWidth-1:0] rr_r;
  logic [ChWidth-1:0] ch_r;
  logic [ChWidth-1:0] grant_ch_s;
  logic [ChWidth-1:0] rr_nx_s;
  logic [ChWidth:0]   cand_s;
  logic               found_s;
  logic               accept_s;
  logic               last_tap_s;

  // Round-robin search starting at rr_r and wrapping past NumCh-1.
  always_comb begin
    found_s    = 1'b0;
    grant_ch_s = '0;
    cand_s     = '0;
    for (int i = 0; i < NumCh; i++) begin
      cand_s = {1'b0, rr_r} + (ChWidth+1)'(i);
      if (cand_s >= (ChWidth+1)'(NumCh)) begin
        cand_s = cand_s - (ChWidth+1)'(NumCh);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && inputValid[cand_s[ChWidth-1:0]]) begin
        found_s    = 1'b1;
        grant_ch_s = cand_s[ChWidth-1:0];
      end else begin
        found_s    = found_s;
        grant_ch_s = grant_ch_s;
      end
    end
  end

  // Accept-side strobes; held low during reset so nothing is captured then.
  always_comb begin
    accept_s   = (state_r == IDLE) && !rst && found_s;
    inputReady = accept_s ? (NumCh'(1) << grant_ch_s) : '0;
    shift      = accept_s;
    flush      = accept_s;
    channel    = accept_s ? grant_ch_s : ch_r;
    last_tap_s = (address == AddrWidth'(Taps - 1));
    rr_nx_s    = (grant_ch_s == ChWidth'(NumCh - 1)) ? '0 : grant_ch_s + ChWidth'(1);
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = MAC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MAC: begin
        if (last_tap_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = MAC;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, arbitration pointer and registered datapath controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      rr_r          <= '0;
      ch_r          <= '0;
      address       <= '0;
      accEn         <= 1'b0;
      outputValid   <= 1'b0;
      outputChannel <= '0;
    end else begin
      state_r     <= state_nx_s;
      accEn       <= (state_nx_s == MAC);
      outputValid <= (state_nx_s == DONE);
      if (accept_s) begin
        rr_r <= rr_nx_s;
        ch_r <= grant_ch_s;
      end
      if (state_nx_s == DONE) begin
        outputChannel <= ch_r;
      end
      // The sweep restarts at tap 0 on accept and parks at 0 after the last tap.
      if ((state_r == MAC) && !last_tap_s) begin
        address <= address + AddrWidth'(1);
      end else begin
        address <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_tdm_ctrl.sv
// Directed bench for fir_tdm_ctrl: reset, single sample, round-robin order,
// wrap-around, requests while busy and reset mid-sweep.
module tb_fir_tdm_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] inputValid;
  logic [3:0] inputReady;
  logic [1:0] channel;
  logic [5:0] address;
  logic       shift;
  logic       flush;
  logic       accEn;
  logic       outputValid;
  logic [1:0] outputChannel;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int accept_cnt = 0;
  int ov_cnt     = 0;
  int ov2_cnt    = 0;

  fir_tdm_ctrl #(.Taps(64), .AddrWidth(6), .NumCh(4), .ChWidth(2)) dut (
    .clk(clk),
    .rst(rst),
    .inputValid(inputValid),
    .inputReady(inputReady),
    .channel(channel),
    .address(address),
    .shift(shift),
    .flush(flush),
    .accEn(accEn),
    .outputValid(outputValid),
    .outputChannel(outputChannel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if ((inputValid & inputReady) != 4'b0000) accept_cnt <= accept_cnt + 1;
    if (outputValid) ov_cnt <= ov_cnt + 1;
    if (outputValid && (outputChannel == 2'd2)) ov2_cnt <= ov2_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while ((inputReady == 4'b0000) && (n < 100)) begin
      tick();
      n++;
    end
    check({tag, "_ready_seen"}, 32'(inputReady != 4'b0000), 32'd1);
  endtask

  task automatic wait_ov(input string tag, output int n);
    n = 0;
    while (!outputValid && (n < 100)) begin
      tick();
      n++;
    end
    check({tag, "_ov_seen"}, 32'(outputValid), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    int t_prev;
    int snap_a;
    int snap_b;
    logic [3:0] exp_grant;

    rst        = 1'b0;
    inputValid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    check("rst_ready", 32'(inputReady), 32'd0);
    check("rst_shift", 32'(shift), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_accen", 32'(accEn), 32'd0);
    check("rst_ov", 32'(outputValid), 32'd0);
    check("rst_och", 32'(outputChannel), 32'd0);
    inputValid = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Single sample on channel 0, full timing.
    inputValid = 4'b0001;
    #1;
    check("A_ready", 32'(inputReady), 32'd1);
    check("A_shift", 32'(shift), 32'd1);
    check("A_flush", 32'(flush), 32'd1);
    check("A_channel", 32'(channel), 32'd0);
    tick();
    inputValid = 4'b0000;
    #1;
    for (int k = 0; k < 64; k++) begin
      check("A_addr", 32'(address), 32'(k));
      check("A_accen", 32'(accEn), 32'd1);
      check("A_busy_ready", 32'(inputReady), 32'd0);
      check("A_busy_shift", 32'(shift), 32'd0);
      tick();
    end
    check("A_ov", 32'(outputValid), 32'd1);
    check("A_och", 32'(outputChannel), 32'd0);
    check("A_done_accen", 32'(accEn), 32'd0);
    check("A_done_addr", 32'(address), 32'd0);
    tick();
    check("A_ov_drop", 32'(outputValid), 32'd0);

    // All channels requesting continuously: order 0,1,2,3,0 every 66 cycles.
    do_reset();
    inputValid = 4'b1111;
    #1;
    t_prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ready("B", n);
      if (g > 0) check("B_spacing", 32'(cyc - t_prev), 32'd66);
      t_prev    = cyc;
      exp_grant = 4'b0001 << (g % 4);
      check("B_grant", 32'(inputReady), 32'(exp_grant));
      wait_ov("B", lat);
      check("B_latency", 32'(lat), 32'd65);
      check("B_och", 32'(outputChannel), 32'(g % 4));
      check("B_done_ready", 32'(inputReady), 32'd0);
      tick();
    end
    inputValid = 4'b0000;

    // Wrap-around: accept channel 2 (rr becomes 3), then 0 and 2 both valid.
    do_reset();
    inputValid = 4'b0100;
    #1;
    check("C_first", 32'(inputReady), 32'd4);
    wait_ov("C1", lat);
    inputValid = 4'b0000;
    tick();
    inputValid = 4'b0101;
    #1;
    check("C_wrap", 32'(inputReady), 32'd1);
    wait_ov("C2", lat);
    check("C_och0", 32'(outputChannel), 32'd0);
    tick();
    check("C_next", 32'(inputReady), 32'd4);
    wait_ov("C3", lat);
    check("C_och2", 32'(outputChannel), 32'd2);
    inputValid = 4'b0000;
    tick();

    // Channel 1 raised mid-sweep: granted in the first idle cycle, exactly once.
    do_reset();
    inputValid = 4'b0001;
    #1;
    tick();
    inputValid = 4'b0000;
    repeat (10) tick();
    inputValid = 4'b0010;
    #1;
    check("D_busy_ready", 32'(inputReady), 32'd0);
    snap_a = accept_cnt;
    wait_ov("D1", lat);
    check("D_och0", 32'(outputChannel), 32'd0);
    check("D_done_ready", 32'(inputReady), 32'd0);
    tick();
    check("D_first_idle", 32'(inputReady), 32'd2);
    wait_ov("D2", lat);
    check("D_och1", 32'(outputChannel), 32'd1);
    check("D_accepts", 32'(accept_cnt - snap_a), 32'd1);
    inputValid = 4'b0000;
    tick();

    // Reset at sweep address 30 aborts the sample; rr returns to 0.
    do_reset();
    inputValid = 4'b0010;
    #1;
    tick();
    inputValid = 4'b0000;
    repeat (30) tick();
    check("E_addr30", 32'(address), 32'd30);
    inputValid = 4'b1111;
    rst = 1'b1;
    #1;
    check("E_rst_addr", 32'(address), 32'd0);
    check("E_rst_accen", 32'(accEn), 32'd0);
    check("E_rst_ov", 32'(outputValid), 32'd0);
    check("E_rst_och", 32'(outputChannel), 32'd0);
    check("E_rst_ready", 32'(inputReady), 32'd0);
    check("E_rst_shift", 32'(shift), 32'd0);
    check("E_rst_flush", 32'(flush), 32'd0);
    check("E_rst_channel", 32'(channel), 32'd0);
    snap_a = ov_cnt;
    tick();
    inputValid = 4'b0000;
    rst = 1'b0;
    repeat (70) tick();
    check("E_no_ov", 32'(ov_cnt - snap_a), 32'd0);
    inputValid = 4'b1001;
    #1;
    check("E_rr_reset", 32'(inputReady), 32'd1);
    wait_ov("E1", lat);
    check("E_och0", 32'(outputChannel), 32'd0);
    inputValid = 4'b0000;
    tick();
    inputValid = 4'b1000;
    #1;
    check("E_ch3_ready", 32'(inputReady), 32'd8);
    check("E_ch3_channel", 32'(channel), 32'd3);
    wait_ov("E2", lat);
    check("E_ch3_latency", 32'(lat), 32'd65);
    check("E_och3", 32'(outputChannel), 32'd3);
    inputValid = 4'b0000;
    tick();

    // One-cycle request on channel 2 while busy is simply lost.
    inputValid = 4'b0001;
    #1;
    tick();
    inputValid = 4'b0000;
    repeat (5) tick();
    inputValid = 4'b0100;
    #1;
    check("F_busy_ready", 32'(inputReady), 32'd0);
    snap_a = accept_cnt;
    snap_b = ov2_cnt;
    tick();
    inputValid = 4'b0000;
    wait_ov("F", lat);
    check("F_och0", 32'(outputChannel), 32'd0);
    repeat (70) tick();
    check("F_no_accept", 32'(accept_cnt - snap_a), 32'd0);
    check("F_no_ov2", 32'(ov2_cnt - snap_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
